i2c_tx_sequencer: RTL and testbench
===================================

# i2c_tx_sequencer

Byte/command sequencer sitting directly upstream of the I2C bit writer (`I2C_write`). Accepts one host request at a time (START, STOP, single bit, or full byte) and drives the writer's enable/qualifier lines. Serializes the byte MSB-first on the writer's `wr_ld` strobes and waits for `wr_finish`. Returns one response per request carrying sticky error flags.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096, clk cycles allowed from `wr_en` rise to `wr_finish` (used only with `I2C_TX_TIMEOUT_EN`)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `req_valid`  in  1  host request present
- `req_ready`  out  1  sequencer can accept request
- `req_cmd`  in  2  00 BYTE, 01 START, 10 STOP, 11 BIT
- `req_data`  in  8  byte payload; BIT uses `req_data[7]`
- `rsp_valid`  out  1  response present, held until `rsp_ready`
- `rsp_ready`  in  1  host accepts response
- `rsp_err`  out  3  [0] write error, [1] bus error, [2] timeout
- `wr_en`  out  1  to writer
- `is_data`  out  1  to writer: 1 data, 0 command
- `is_byte`  out  1  to writer: 1 byte, 0 single bit
- `command_o`  out  1  to writer `command_i`: 1 START, 0 STOP
- `data_o`  out  1  to writer `data_i`; always `shift[7]`
- `wr_ld`  in  1  writer consumed current bit
- `wr_finish`  in  1  writer operation complete
- `wr_err`  in  1  writer saw SDA mismatch
- `bus_err`  in  1  writer saw illegal SDA change during SCL high

## Operation
- States: IDLE, ACTIVE, RELEASE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`: latch `req_data` into `shift[7:0]`, decode `req_cmd` into `is_data`/`is_byte`/`command_o`, clear error latch, go ACTIVE.
- Decode: BYTE → is_data=1,is_byte=1; BIT → is_data=1,is_byte=0; START → is_data=0,command_o=1; STOP → is_data=0,command_o=0. Qualifiers stay stable from ACTIVE entry to RESP exit.
- ACTIVE: `wr_en`=1. Each `wr_ld` shifts `shift <= {shift[6:0],1'b0}`. `wr_err`/`bus_err` ORed into sticky latch every cycle. On `wr_finish` → RELEASE (errors asserted in the same cycle are captured).
- RELEASE: `wr_en`=0, one cycle, → RESP.
- RESP: `rsp_valid`=1, `rsp_err` = latch. On `rsp_ready` → IDLE.
- `wr_ld`, `wr_err`, `bus_err`, `wr_finish` ignored outside ACTIVE.
- `wr_ld` and `wr_finish` in the same cycle: shift still performed, then RELEASE.
- More than 8 `wr_ld` in BYTE: shift zero-fills, no error.

## Timing
- Reset values: `req_ready`=0 during reset, 1 in first cycle after release; `rsp_valid`=0, `rsp_err`=0, `wr_en`=0, `is_data`=0, `is_byte`=0, `command_o`=0, `shift`=0 (so `data_o`=0); state IDLE.
- Accept at cycle N → `wr_en`, qualifiers and `data_o`=req_data[7] valid at N+1.
- `wr_ld` at cycle K → new `data_o` at K+1.
- `wr_finish` at F → `wr_en`=0 at F+1, `rsp_valid`=1 at F+2.
- Minimum accept-to-accept spacing: response handshake cycle + 1.
- Reset mid-operation: all registers return to reset values asynchronously; no response issued for the aborted request.
- All outputs registered.

## Configuration
- `I2C_TX_TIMEOUT_EN` defined: counter cleared on ACTIVE entry, increments each ACTIVE cycle; reaching `TIMEOUT_CYCLES` without `wr_finish` sets `rsp_err[2]` and goes RELEASE. Width `$clog2(TIMEOUT_CYCLES+1)`.
- Undefined: no counter; `rsp_err[2]` constant 0; ACTIVE waits indefinitely.

## Structure
- Shared package `i2c_pkg`: `req_cmd` encodings (CMD_BYTE, CMD_START, CMD_STOP, CMD_BIT), `rsp_err` bit indices, state enum.
- One sub-module: `i2c_tx_watchdog` (timeout counter, clear/enable in, expired out), instantiated only under `I2C_TX_TIMEOUT_EN`. Shifter and FSM stay inline.

## Test plan
- BYTE 0xA5, writer model pulses `wr_ld` 8 times → `data_o` sequence 1,0,1,0,0,1,0,1; `rsp_err`=000; `wr_en` low exactly one cycle after `wr_finish`.
- START then STOP → is_data=0, command_o=1 then 0, is_byte=0; two responses with `rsp_err`=000.
- BIT with req_data=0x80 plus `bus_err` pulse mid-ACTIVE → `data_o`=1 at N+1; `rsp_err`=010.
- BYTE 0x3C with `wr_err` and `wr_finish` in same cycle → `rsp_err`=001; `req_ready` stays 0 while `rsp_ready` held low for 5 cycles.
- `rst_n` asserted during BYTE after 3 `wr_ld` → all outputs at reset values immediately; next request accepted normally with `rsp_err`=000.
- With `I2C_TX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no `wr_finish` → `wr_en` drops after 16 ACTIVE cycles, `rsp_err`=100.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transmit sequencer.
// Holds the host command encodings, response error bit positions and the
// sequencer state enum.
package i2c_pkg;

    // req_cmd encodings
    localparam logic [1:0] CMD_BYTE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_BIT   = 2'b11;

    // rsp_err bit indices
    localparam int unsigned ERR_WR      = 0;
    localparam int unsigned ERR_BUS     = 1;
    localparam int unsigned ERR_TIMEOUT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StRelease,
        StResp
    } state_e;

endpackage

// File: rtl/i2c_tx_sequencer_if.sv
// Bundle of the host request/response handshake and the I2C bit-writer lines.
// Modports:
//   slave  - the sequencer side (takes requests, drives the writer)
//   master - the environment side (host plus writer)
interface i2c_tx_sequencer_if;
    // host request / response
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_err;
    // bit-writer side
    logic       wr_en;
    logic       is_data;
    logic       is_byte;
    logic       command_o;
    logic       data_o;
    logic       wr_ld;
    logic       wr_finish;
    logic       wr_err;
    logic       bus_err;

    modport slave (
        input  req_valid, req_cmd, req_data, rsp_ready, wr_ld, wr_finish, wr_err, bus_err,
        output req_ready, rsp_valid, rsp_err, wr_en, is_data, is_byte, command_o, data_o
    );

    modport master (
        output req_valid, req_cmd, req_data, rsp_ready, wr_ld, wr_finish, wr_err, bus_err,
        input  req_ready, rsp_valid, rsp_err, wr_en, is_data, is_byte, command_o, data_o
    );
endinterface

// File: rtl/i2c_tx_watchdog.sv
// Timeout counter for the transmit sequencer.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   clear      - zero the counter (request accepted)
//   enable     - count this cycle (sequencer is ACTIVE)
//   expired    - this is the TIMEOUT_CYCLES-th enabled cycle since clear
module i2c_tx_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    // cnt_q counts enabled cycles already elapsed, so the current cycle is
    // number cnt_q+1; firing at TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES
    // cycles of wr_en before it drops.
    assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_tx_sequencer.sv
// Byte/command sequencer in front of the I2C bit writer.
// Takes one host request at a time (BYTE, START, STOP, BIT), drives the
// writer qualifiers, shifts the byte out MSB-first on wr_ld, waits for
// wr_finish and returns one response with sticky error flags.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   bus        - i2c_tx_sequencer_if.slave (host handshake + writer lines)
// Optional feature: define I2C_TX_TIMEOUT_EN to enable the TIMEOUT_CYCLES
// watchdog (rsp_err[2]); otherwise ACTIVE waits for wr_finish indefinitely.
module i2c_tx_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_tx_sequencer_if.slave     bus
);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] err_q, err_d;
    logic       is_data_q, is_data_d;
    logic       is_byte_q, is_byte_d;
    logic       command_q, command_d;
    logic       req_ready_q, rsp_valid_q, wr_en_q;
    logic       accept;
    logic       timeout_hit;

    // req_ready_q is only high while IDLE
    assign accept = bus.req_valid && req_ready_q;

`ifdef I2C_TX_TIMEOUT_EN
    i2c_tx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q == StActive),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        err_d     = err_q;
        is_data_d = is_data_q;
        is_byte_d = is_byte_q;
        command_d = command_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = bus.req_data;
                    err_d   = '0;
                    state_d = StActive;
                    unique case (bus.req_cmd)
                        CMD_BYTE:  begin is_data_d = 1'b1; is_byte_d = 1'b1; command_d = 1'b0; end
                        CMD_BIT:   begin is_data_d = 1'b1; is_byte_d = 1'b0; command_d = 1'b0; end
                        CMD_START: begin is_data_d = 1'b0; is_byte_d = 1'b0; command_d = 1'b1; end
                        CMD_STOP:  begin is_data_d = 1'b0; is_byte_d = 1'b0; command_d = 1'b0; end
                        default:   ;
                    endcase
                end
            end
            StActive: begin
                // Shift still happens when wr_ld and wr_finish coincide
                if (bus.wr_ld) begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
                err_d[ERR_WR]  = err_q[ERR_WR] | bus.wr_err;
                err_d[ERR_BUS] = err_q[ERR_BUS] | bus.bus_err;
                if (bus.wr_finish) begin
                    state_d = StRelease;
                end else if (timeout_hit) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = StRelease;
                end
            end
            StRelease: begin
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            err_q       <= '0;
            is_data_q   <= 1'b0;
            is_byte_q   <= 1'b0;
            command_q   <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            is_data_q   <= is_data_d;
            is_byte_q   <= is_byte_d;
            command_q   <= command_d;
            // Handshake outputs registered from the next state
            req_ready_q <= (state_d == StIdle);
            rsp_valid_q <= (state_d == StResp);
            wr_en_q     <= (state_d == StActive);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.is_data   = is_data_q;
    assign bus.is_byte   = is_byte_q;
    assign bus.command_o = command_q;
    assign bus.data_o    = shift_q[7];

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Directed self-checking bench for i2c_tx_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_i2c_tx_sequencer;
    import i2c_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    i2c_tx_sequencer_if bus();

    i2c_tx_sequencer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge with req_ready high; returns one cycle later (N+1).
    task automatic accept(input logic [1:0] cmd, input logic [7:0] d);
        chk("req_ready before accept", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_data  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready after accept", bus.req_ready, 0);
        chk("wr_en at N+1", bus.wr_en, 1);
    endtask

    // Pulse wr_finish (optionally with wr_ld/errors), then run the response
    // handshake after holding rsp_ready low for 'hold' cycles.
    task automatic finish_resp(input string tag, input logic ld, input logic we, input logic be,
                               input int hold, input logic [2:0] exp_err);
        bus.wr_finish = 1'b1;
        bus.wr_ld     = ld;
        bus.wr_err    = we;
        bus.bus_err   = be;
        @(negedge clk);
        bus.wr_finish = 1'b0;
        bus.wr_ld     = 1'b0;
        bus.wr_err    = 1'b0;
        bus.bus_err   = 1'b0;
        chk({tag, " wr_en at F+1"}, bus.wr_en, 0);
        chk({tag, " rsp_valid at F+1"}, bus.rsp_valid, 0);
        @(negedge clk);
        chk({tag, " rsp_valid at F+2"}, bus.rsp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            // errors outside ACTIVE must not reach the latch
            bus.bus_err = 1'b1;
            bus.wr_err  = 1'b1;
            @(negedge clk);
            chk({tag, " req_ready while held"}, bus.req_ready, 0);
            chk({tag, " rsp_valid while held"}, bus.rsp_valid, 1);
        end
        bus.bus_err = 1'b0;
        bus.wr_err  = 1'b0;
        chk({tag, " rsp_err"}, bus.rsp_err, exp_err);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid after handshake"}, bus.rsp_valid, 0);
        chk({tag, " req_ready after handshake"}, bus.req_ready, 1);
    endtask

    initial begin
        logic [7:0] pat;
        int         cnt;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.wr_ld     = 1'b0;
        bus.wr_finish = 1'b0;
        bus.wr_err    = 1'b0;
        bus.bus_err   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset wr_en", bus.wr_en, 0);
        chk("reset quals", {bus.is_data, bus.is_byte, bus.command_o}, 0);
        chk("reset data_o", bus.data_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready first cycle", bus.req_ready, 1);

        // BYTE 0xA5, 8 wr_ld then 2 extra (zero fill)
        pat = 8'hA5;
        accept(CMD_BYTE, pat);
        chk("byte quals", {bus.is_data, bus.is_byte}, 2'b11);
        for (int i = 7; i >= 0; i--) begin
            chk("byte A5 data_o", bus.data_o, pat[i]);
            bus.wr_ld = 1'b1;
            @(negedge clk);
            bus.wr_ld = 1'b0;
        end
        chk("byte after 8 ld", bus.data_o, 0);
        bus.wr_ld = 1'b1;
        repeat (2) @(negedge clk);
        bus.wr_ld = 1'b0;
        chk("byte zero fill", bus.data_o, 0);
        finish_resp("byteA5", 1'b0, 1'b0, 1'b0, 0, 3'b000);

        // START then STOP
        accept(CMD_START, 8'hFF);
        chk("start quals", {bus.is_data, bus.is_byte, bus.command_o}, 3'b001);
        @(negedge clk);
        finish_resp("start", 1'b0, 1'b0, 1'b0, 0, 3'b000);
        accept(CMD_STOP, 8'hFF);
        chk("stop quals", {bus.is_data, bus.is_byte, bus.command_o}, 3'b000);
        finish_resp("stop", 1'b0, 1'b0, 1'b0, 0, 3'b000);

        // BIT 0x80 with bus_err mid-ACTIVE
        accept(CMD_BIT, 8'h80);
        chk("bit data_o", bus.data_o, 1);
        chk("bit quals", {bus.is_data, bus.is_byte, bus.command_o}, 3'b100);
        bus.bus_err = 1'b1;
        @(negedge clk);
        bus.bus_err = 1'b0;
        @(negedge clk);
        finish_resp("bit", 1'b0, 1'b0, 1'b0, 0, 3'b010);

        // BYTE 0x3C: one ld, then wr_ld + wr_err + wr_finish together, rsp_ready held 5
        accept(CMD_BYTE, 8'h3C);
        chk("3C data_o", bus.data_o, 0);
        bus.wr_ld = 1'b1;
        @(negedge clk);
        bus.wr_ld = 1'b0;
        chk("3C data_o after ld", bus.data_o, 0);
        finish_resp("byte3C", 1'b1, 1'b1, 1'b0, 5, 3'b001);

        // Reset mid-BYTE after 3 wr_ld
        accept(CMD_BYTE, 8'h1F);
        bus.wr_ld = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr_ld = 1'b0;
        chk("1F data_o after 3 ld", bus.data_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset wr_en", bus.wr_en, 0);
        chk("midreset req_ready", bus.req_ready, 0);
        chk("midreset data_o", bus.data_o, 0);
        chk("midreset quals", {bus.is_data, bus.is_byte, bus.command_o}, 0);
        chk("midreset rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset rsp_valid", bus.rsp_valid, 0);
        accept(CMD_BYTE, 8'h81);
        chk("post-reset data_o", bus.data_o, 1);
        finish_resp("post-reset", 1'b0, 1'b0, 1'b0, 0, 3'b000);

`ifdef I2C_TX_TIMEOUT_EN
        // No wr_finish: wr_en stays high for exactly 16 cycles
        accept(CMD_BYTE, 8'h00);
        cnt = 0;
        while (bus.wr_en && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout wr_en cycles", 8'(cnt), 8'd16);
        @(negedge clk);
        chk("timeout rsp_valid", bus.rsp_valid, 1);
        chk("timeout rsp_err", bus.rsp_err, 3'b100);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("timeout req_ready", bus.req_ready, 1);
`else
        cnt = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
